ifetch_buffer: RTL and testbench



---
 rtl/ifetch_pkg.sv | 26 ++
 rtl/ifetch_buffer_store.sv | 63 ++++++
 rtl/ifetch_buffer.sv | 138 +++++++++++++
 tb/tb_ifetch_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.

// Fallback when opcodes.sv is not part of the build; its definition wins otherwise.
`ifndef NOP
`define NOP 64'h0000_0000_0000_0013
`endif

package ifetch_pkg;

  localparam int unsigned IFB_ADDR_W  = 64;
  localparam int unsigned IFB_DATA_W  = 64;
  localparam int unsigned NUM_ENTRIES = 2;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [IFB_ADDR_W-1:0] tag;
    logic [IFB_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/ifetch_buffer_store.sv
// Two-entry fully tagged instruction store: combinational lookup/probe,
// synchronous fill and bulk invalidate.

module ifetch_buffer_store
  import ifetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [IFB_ADDR_W-1:0]  i_lookup_addr,
  output logic [NUM_ENTRIES-1:0] o_hit,
  output logic                   o_hit_idx,
  output logic [IFB_DATA_W-1:0]  o_hit_data,
  input  logic [IFB_ADDR_W-1:0]  i_probe_addr,
  output logic                   o_probe_hit,
  input  logic                   i_inv_all,
  input  logic                   i_fill_en,
  input  logic                   i_fill_idx,
  input  logic [IFB_ADDR_W-1:0]  i_fill_tag,
  input  logic [IFB_DATA_W-1:0]  i_fill_data
);

  entry_t r_entry [NUM_ENTRIES];

  // Entry array: invalidate dominates a same-cycle fill.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_entry[i] <= '0;
      end
    end else if (i_inv_all) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_entry[i].valid <= 1'b0;
      end
    end else if (i_fill_en) begin
      r_entry[i_fill_idx].valid <= 1'b1;
      r_entry[i_fill_idx].tag   <= i_fill_tag;
      r_entry[i_fill_idx].data  <= i_fill_data;
    end
  end

  // Tag compare for the fetch address and for the sequential-prefetch probe.
  always_comb begin
    o_hit       = '0;
    o_probe_hit = 1'b0;
    o_hit_idx   = 1'b0;
    o_hit_data  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      o_hit[i] = r_entry[i].valid && (r_entry[i].tag == i_lookup_addr);
      if (r_entry[i].valid && (r_entry[i].tag == i_probe_addr)) begin
        o_probe_hit = 1'b1;
      end
    end
    // Duplicate tags cannot arise with a single outstanding fill; entry 1 wins if they did.
    if (o_hit[1]) begin
      o_hit_idx  = 1'b1;
      o_hit_data = r_entry[1].data;
    end else if (o_hit[0]) begin
      o_hit_idx  = 1'b0;
      o_hit_data = r_entry[0].data;
    end
  end

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction-side memory port: serves fetch combinationally from a 2-entry
// buffer, stalls on a miss and keeps one request outstanding on the memory bus,
// optionally prefetching the next sequential word.

module ifetch_buffer
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = IFB_ADDR_W,
  parameter int unsigned DATA_W      = IFB_DATA_W,
  parameter int unsigned INSTR_BYTES = 8,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_read_in,
  input  logic [ADDR_W-1:0] instr_address_in,
  output logic [DATA_W-1:0] instr_read_value_out,
  output logic              stall_out,
  input  logic              flush_in,
  output logic              mem_req_valid_out,
  input  logic              mem_req_ready_in,
  output logic [ADDR_W-1:0] mem_req_addr_out,
  input  logic              mem_resp_valid_in,
  input  logic [DATA_W-1:0] mem_resp_data_in
);

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [ADDR_W-1:0]   w_req_addr_next;
  logic                r_repl_ptr;
  logic                r_discard;
  logic                w_discard_next;

  logic [NUM_ENTRIES-1:0] w_hit;
  logic                   w_hit_idx;
  logic [DATA_W-1:0]      w_hit_data;
  logic                   w_any_hit;
  logic                   w_probe_hit;
  logic [ADDR_W-1:0]      w_next_addr;
  logic                   w_fwd;
  logic                   w_fill_en;
  logic                   w_fill_idx;

  // Wraps modulo 2^ADDR_W by construction.
  assign w_next_addr = instr_address_in + ADDR_W'(INSTR_BYTES);
  assign w_any_hit   = |w_hit;

  // Never evict the entry the fetch stage is currently hitting.
  assign w_fill_idx = w_any_hit ? ~w_hit_idx : r_repl_ptr;

  ifetch_buffer_store u_store (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_lookup_addr (instr_address_in),
    .o_hit         (w_hit),
    .o_hit_idx     (w_hit_idx),
    .o_hit_data    (w_hit_data),
    .i_probe_addr  (w_next_addr),
    .o_probe_hit   (w_probe_hit),
    .i_inv_all     (flush_in),
    .i_fill_en     (w_fill_en),
    .i_fill_idx    (w_fill_idx),
    .i_fill_tag    (r_req_addr),
    .i_fill_data   (mem_resp_data_in)
  );

  // Fetch-side outputs: a live response for the fetch address beats the buffer.
  always_comb begin
    w_fwd = (r_state == StWait) && mem_resp_valid_in && !r_discard && !flush_in &&
            (r_req_addr == instr_address_in);
    if (w_fwd) begin
      instr_read_value_out = mem_resp_data_in;
    end else if (w_any_hit) begin
      instr_read_value_out = w_hit_data;
    end else begin
      instr_read_value_out = `NOP;
    end
    stall_out         = instr_read_in && !(w_any_hit || w_fwd);
    mem_req_valid_out = (r_state == StReq);
    mem_req_addr_out  = r_req_addr;
  end

  // Request FSM: demand miss beats prefetch; request held stable until accepted.
  always_comb begin
    w_state_next    = r_state;
    w_req_addr_next = r_req_addr;
    w_discard_next  = r_discard;
    w_fill_en       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (stall_out) begin
          w_state_next    = StReq;
          w_req_addr_next = instr_address_in;
        end else if (PREFETCH_EN && instr_read_in && w_any_hit && !w_probe_hit) begin
          w_state_next    = StReq;
          w_req_addr_next = w_next_addr;
        end
      end
      StReq: begin
        if (flush_in) begin
          w_discard_next = 1'b1;
        end
        if (mem_req_ready_in) begin
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (mem_resp_valid_in) begin
          w_state_next   = StIdle;
          w_fill_en      = !r_discard && !flush_in;
          w_discard_next = 1'b0;
        end else if (flush_in) begin
          w_discard_next = 1'b1;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State, request address, replacement pointer and discard flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_req_addr <= '0;
      r_repl_ptr <= 1'b0;
      r_discard  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_req_addr <= w_req_addr_next;
      r_repl_ptr <= r_repl_ptr ^ w_fill_en;
      r_discard  <= w_discard_next;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer: a memory model with configurable latency,
// a scoreboard of expected instruction words and a log of accepted requests.

module tb_ifetch_buffer;

  localparam logic [63:0] NOP_WORD = 64'h0000_0000_0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_read_in;
  logic [63:0] instr_address_in;
  logic [63:0] instr_read_value_out;
  logic        stall_out;
  logic        flush_in;
  logic        mem_req_valid_out;
  logic        mem_req_ready_in;
  logic [63:0] mem_req_addr_out;
  logic        mem_resp_valid_in;
  logic [63:0] mem_resp_data_in;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q [$];
  logic [63:0] acc_q [$];
  logic [63:0] pend_addr [$];
  longint      pend_due [$];
  longint      cyc = 0;
  int          mem_lat = 0;
  logic        stray_pend = 1'b0;
  logic [63:0] stray_addr = '0;

  always #5 clk = ~clk;

  ifetch_buffer dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .instr_read_in        (instr_read_in),
    .instr_address_in     (instr_address_in),
    .instr_read_value_out (instr_read_value_out),
    .stall_out            (stall_out),
    .flush_in             (flush_in),
    .mem_req_valid_out    (mem_req_valid_out),
    .mem_req_ready_in     (mem_req_ready_in),
    .mem_req_addr_out     (mem_req_addr_out),
    .mem_resp_valid_in    (mem_resp_valid_in),
    .mem_resp_data_in     (mem_resp_data_in)
  );

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h1000) return 64'hDEAD_BEEF;
    return {~a[31:0], a[31:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_acc(input string tag, input logic [63:0] exp);
    logic [63:0] got;
    got = '1;
    if (acc_q.size() > 0) got = acc_q.pop_front();
    check_eq(tag, got, exp);
  endtask

  // Drive one fetch address and hold it until served; stalls counted on the way.
  task automatic fetch_one(input logic [63:0] a, input int exp_stall, input string tag);
    int          n;
    bit          done;
    logic [63:0] exp_w;
    n    = 0;
    done = 1'b0;
    exp_q.push_back(mem_word(a));
    instr_read_in    = 1'b1;
    instr_address_in = a;
    while (!done && n < 40) begin
      @(negedge clk);
      if (!stall_out) begin
        exp_w = exp_q.pop_front();
        check_eq({tag, "_data"}, instr_read_value_out, exp_w);
        done = 1'b1;
      end else begin
        n++;
      end
      next_cycle();
    end
    check_eq({tag, "_served"}, 64'(done), 64'd1);
    check_eq({tag, "_stalls"}, 64'(n), 64'(exp_stall));
  endtask

  task automatic settle();
    instr_read_in = 1'b0;
    flush_in      = 1'b0;
    repeat (6) next_cycle();
    acc_q.delete();
  endtask

  // Memory model: records handshakes, answers in order after mem_lat extra cycles.
  initial begin
    mem_resp_valid_in = 1'b0;
    mem_resp_data_in  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (mem_req_valid_out && mem_req_ready_in) begin
        pend_addr.push_back(mem_req_addr_out);
        pend_due.push_back(cyc + 1 + longint'(mem_lat));
        acc_q.push_back(mem_req_addr_out);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (stray_pend) begin
        mem_resp_valid_in = 1'b1;
        mem_resp_data_in  = mem_word(stray_addr);
        stray_pend        = 1'b0;
      end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        mem_resp_valid_in = 1'b1;
        mem_resp_data_in  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        mem_resp_valid_in = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n          = 1'b0;
    instr_read_in    = 1'b0;
    instr_address_in = '0;
    flush_in         = 1'b0;
    mem_req_ready_in = 1'b1;
    next_cycle();
    instr_read_in    = 1'b1;
    instr_address_in = 64'h1000;
    @(negedge clk);
    check_eq("rst_req_valid", mem_req_valid_out, 0);
    check_eq("rst_req_addr", mem_req_addr_out, 0);
    check_eq("rst_stall", stall_out, 1);
    check_eq("rst_value", instr_read_value_out, NOP_WORD);
    next_cycle();
    reset_n = 1'b1;
    acc_q.delete();

    // Cold miss, then sequential prefetch and replacement.
    fetch_one(64'h1000, 2, "cold");
    fetch_one(64'h1000, 0, "pf_hit0");
    fetch_one(64'h1000, 0, "pf_hit1");
    fetch_one(64'h1008, 0, "pf_fwd");
    fetch_one(64'h1008, 0, "pf_hit2");
    fetch_one(64'h1008, 0, "pf_hit3");
    fetch_one(64'h1008, 0, "pf_hit4");
    fetch_one(64'h1008, 0, "pf_keep");
    fetch_one(64'h1000, 2, "pf_evict");
    fetch_one(64'h1010, 0, "pf_new");
    check_acc("acc_cold", 64'h1000);
    check_acc("acc_pf1", 64'h1008);
    check_acc("acc_pf2", 64'h1010);
    check_acc("acc_evict", 64'h1000);

    // Backpressure with a redirect while the request is pending.
    settle();
    mem_req_ready_in = 1'b0;
    instr_read_in    = 1'b1;
    instr_address_in = 64'h2000;
    @(negedge clk);
    check_eq("bp_miss", stall_out, 1);
    next_cycle();
    instr_address_in = 64'h3000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("bp_valid", mem_req_valid_out, 1);
      check_eq("bp_addr", mem_req_addr_out, 64'h2000);
      check_eq("bp_stall", stall_out, 1);
      next_cycle();
    end
    mem_req_ready_in = 1'b1;
    fetch_one(64'h3000, 4, "bp_redirect");
    check_acc("acc_bp0", 64'h2000);
    check_acc("acc_bp1", 64'h3000);
    fetch_one(64'h2000, 0, "bp_filled");

    // Flush while waiting for a response.
    settle();
    fetch_one(64'h2000, 0, "fl_pre");
    mem_lat          = 2;
    instr_address_in = 64'h4000;
    @(negedge clk);
    check_eq("fl_miss", stall_out, 1);
    next_cycle();
    @(negedge clk);
    check_eq("fl_req_valid", mem_req_valid_out, 1);
    next_cycle();
    flush_in = 1'b1;
    mem_lat  = 0;
    @(negedge clk);
    check_eq("fl_stall_flush", stall_out, 1);
    next_cycle();
    flush_in = 1'b0;
    @(negedge clk);
    check_eq("fl_stall_wait", stall_out, 1);
    next_cycle();
    @(negedge clk);
    check_eq("fl_nofwd", stall_out, 1);
    check_eq("fl_nop", instr_read_value_out, NOP_WORD);
    next_cycle();
    fetch_one(64'h4000, 2, "fl_refetch");
    fetch_one(64'h2000, 2, "fl_inv0");
    fetch_one(64'h2008, 2, "fl_inv1");
    check_acc("acc_fl0", 64'h4000);
    check_acc("acc_fl1", 64'h4000);
    check_acc("acc_fl2", 64'h2000);
    check_acc("acc_fl3", 64'h2008);

    // Flush in the same cycle as the response.
    settle();
    instr_read_in    = 1'b1;
    instr_address_in = 64'h5000;
    @(negedge clk);
    check_eq("co_miss", stall_out, 1);
    next_cycle();
    next_cycle();
    flush_in = 1'b1;
    @(negedge clk);
    check_eq("co_stall", stall_out, 1);
    check_eq("co_value", instr_read_value_out, NOP_WORD);
    next_cycle();
    flush_in = 1'b0;
    fetch_one(64'h5000, 2, "co_refetch");
    check_acc("acc_co0", 64'h5000);
    check_acc("acc_co1", 64'h5000);

    // Reset while a request is outstanding, then a stray response in idle.
    settle();
    mem_lat          = 2;
    instr_read_in    = 1'b1;
    instr_address_in = 64'h6000;
    @(negedge clk);
    check_eq("rm_miss", stall_out, 1);
    next_cycle();
    next_cycle();
    reset_n = 1'b0;
    @(negedge clk);
    stray_addr = 64'h6000;
    stray_pend = 1'b1;
    next_cycle();
    reset_n       = 1'b1;
    instr_read_in = 1'b0;
    mem_lat       = 0;
    @(negedge clk);
    check_eq("rm_req_valid", mem_req_valid_out, 0);
    check_eq("rm_value", instr_read_value_out, NOP_WORD);
    next_cycle();
    fetch_one(64'h6000, 2, "rm_after");
    check_acc("acc_rm0", 64'h6000);
    check_acc("acc_rm1", 64'h6000);

    check_eq("sb_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
